pc_fetch_seq: RTL
=================

Name: pc_fetch_seq

Overview:
- Fetch sequencer that owns the PC register and drives the instruction-memory request handshake.
- Feeds the next-PC unit: PC1 is the fetch PC (`pc`), PC2 is the PC of the instruction in decode (`pc_id`). Loads that unit's `npc` result on each fetch completion.
- Handles hazard stalls, exception redirect, and a fetch-timeout watchdog.
- Sits between the next-PC unit, the instruction memory port and the decode stage.

Parameters:
- RESET_PC, 32'h0000_3000, byte address loaded into `pc` on reset (bits [1:0] ignored).
- EXC_PC, 32'h0000_4180, byte address of the exception/timeout vector (bits [1:0] ignored).
- TIMEOUT, 16, maximum WAIT cycles before a fetch error; legal range 2..255.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- npc  in  30  next PC word address from the next-PC unit (combinational from `pc`/`pc_id`).
- stall  in  1  decode cannot accept a new instruction.
- exc_valid  in  1  exception request, single-cycle pulse.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  30  fetch word address, always equal to `pc`.
- imem_ack  in  1  fetch data valid this cycle.
- imem_rdata  in  32  fetched instruction.
- pc  out  30  current fetch PC (PC1 of the next-PC unit).
- pc_id  out  30  PC of the instruction held in `ir` (PC2 of the next-PC unit).
- ir  out  32  instruction presented to decode.
- ir_valid  out  1  `ir` holds a valid, unconsumed instruction.
- fetch_err  out  1  one-cycle pulse on fetch timeout.

Behaviour:
- Reset (`rst_n`=0 at a clk edge):
  - pc=RESET_PC[31:2], pc_id=RESET_PC[31:2], ir=32'h0.
  - ir_valid=0, imem_req=0, fetch_err=0.
  - state=IDLE, wait counter=0, exc_pend=0.
  - Reset taken mid-fetch abandons the request; the memory must tolerate `imem_req` dropping.
- States: IDLE, WAIT, HOLD.
- IDLE:
  - Lasts one cycle after reset or after a completed fetch.
  - imem_req=0. Next state is WAIT, with the counter cleared.
- WAIT:
  - imem_req=1 and imem_addr=pc; both are held stable until ack.
  - The counter increments every cycle without ack.
  - On imem_ack with exc_pend=0: ir<=imem_rdata, pc_id<=pc, ir_valid<=1.
    - If stall=0: pc<=npc, go IDLE.
    - If stall=1: go HOLD, pc unchanged.
  - On imem_ack with exc_pend=1: discard data, ir_valid<=0, pc<=EXC_PC[31:2], exc_pend<=0, go IDLE.
  - When counter reaches TIMEOUT with no ack: fetch_err pulses 1 cycle, pc<=EXC_PC[31:2], ir_valid<=0, go IDLE. A late ack for the abandoned fetch is ignored because imem_req is low.
- HOLD:
  - imem_req=0; ir, pc_id and ir_valid are held.
  - When stall=0, the next edge sets pc<=npc and goes IDLE.
  - `npc` is sampled only on that edge, since `pc_id` is stable during HOLD.
- ir_valid clears on the edge that leaves WAIT or HOLD for IDLE with stall=0, unless a new ack occurs on the same edge. Decode consumes `ir` when ir_valid=1 and stall=0.
- exc_valid handling:
  - In IDLE or HOLD: the next edge sets pc<=EXC_PC[31:2], ir_valid<=0, state IDLE. Exception takes priority over stall.
  - In WAIT: sets exc_pend; redirect happens on ack or on timeout.
  - exc_valid together with timeout on the same edge: a single redirect, and fetch_err still pulses.
- Arithmetic: all PCs are 30-bit word addresses and wrap modulo 2^30. Minimum throughput is one instruction per 3 cycles (IDLE, WAIT, ack).

Decomposition:
- Shared package (cpu_pkg):
  - state encoding localparams S_IDLE=2'd0, S_WAIT=2'd1, S_HOLD=2'd2;
  - RESET_PC and EXC_PC default constants;
  - the 30-bit word-address width constant shared with the next-PC unit.
- One sub-module, fetch_timer: 8-bit counter with clear, enable, and a `hit` flag at TIMEOUT.
- The FSM and PC register stay in pc_fetch_seq.

Test Plan:
- Reset then ack one cycle after req, npc=pc+1, stall=0: imem_addr = 0xC00, 0xC01, 0xC02 on successive fetches; pc_id tracks them; ir_valid pulses.
- Branch redirect: with pc_id=0xC01, npc=0xD00 at ack → next imem_addr=0xD00 and pc_id=0xC02 for that fetch.
- stall=1 for 4 cycles at ack → HOLD; ir, pc_id and ir_valid=1 held; imem_req=0; after stall drops, pc=npc and the next fetch is issued.
- No ack for 16 WAIT cycles → fetch_err pulses once; next imem_addr=0x1060 (EXC_PC>>2); a later stray ack is ignored.
- exc_valid during WAIT, ack 3 cycles later with rdata=32'h2408_0001 → ir not updated, ir_valid=0, next imem_addr=0x1060.
- rst_n=0 during WAIT → next cycle imem_req=0, pc=0xC00, ir_valid=0; fetch restarts from 0xC00.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: fetch FSM encoding, reset/exception
// vectors, and the word-address width used by the fetch sequencer and the
// next-PC unit.
package cpu_pkg;

    localparam int unsigned WORD_AW = 30;   // word address width (byte addr [31:2])
    localparam int unsigned XLEN    = 32;   // instruction width
    localparam int unsigned TMR_W   = 8;    // fetch watchdog counter width

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
    localparam logic [31:0] EXC_PC_DEF   = 32'h0000_4180;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = S_IDLE,
        ST_WAIT = S_WAIT,
        ST_HOLD = S_HOLD
    } fetch_state_e;

    typedef logic [WORD_AW-1:0] waddr_t;

    // Instruction handed to decode together with its own PC.
    typedef struct packed {
        waddr_t          pc;
        logic [XLEN-1:0] insn;
    } fetch_pkt_t;

endpackage

// File: rtl/pc_fetch_seq_if.sv
// Fetch sequencer bus: next-PC unit inputs, hazard/exception controls,
// instruction-memory handshake and the decode-side instruction register.
//   master : the fetch sequencer (drives imem_req/imem_addr, pc, pc_id, ir, ir_valid, fetch_err)
//   slave  : the surrounding pipeline / memory (drives npc, stall, exc_valid, imem_ack, imem_rdata)
interface pc_fetch_seq_if;
    import cpu_pkg::*;

    waddr_t          npc;
    logic            stall;
    logic            exc_valid;
    logic            imem_req;
    waddr_t          imem_addr;
    logic            imem_ack;
    logic [XLEN-1:0] imem_rdata;
    waddr_t          pc;
    waddr_t          pc_id;
    logic [XLEN-1:0] ir;
    logic            ir_valid;
    logic            fetch_err;

    modport master (
        input  npc, stall, exc_valid, imem_ack, imem_rdata,
        output imem_req, imem_addr, pc, pc_id, ir, ir_valid, fetch_err
    );

    modport slave (
        output npc, stall, exc_valid, imem_ack, imem_rdata,
        input  imem_req, imem_addr, pc, pc_id, ir, ir_valid, fetch_err
    );
endinterface

// File: rtl/fetch_timer.sv
// Fetch watchdog counter.
//   clk, rst_n : clock, synchronous active-low reset
//   i_clr      : clear counter to zero (wins over i_en)
//   i_en       : count one unanswered WAIT cycle
//   o_hit_c    : current cycle is the TIMEOUT-th unanswered WAIT cycle
module fetch_timer
    import cpu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_hit_c
);

    logic [TMR_W-1:0] r_cnt;

    // Count of WAIT cycles already spent without an ack.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + TMR_W'(1);
        end
    end

    // Count starts at 0 in the first WAIT cycle, so TIMEOUT-1 marks the last allowed one.
    assign o_hit_c = (r_cnt == TMR_W'(TIMEOUT - 1));

endmodule

// File: rtl/pc_fetch_seq.sv
// Fetch sequencer: owns the fetch PC, runs the instruction-memory request
// handshake, presents fetched instructions to decode and handles stalls,
// exception redirect and the fetch watchdog.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : pc_fetch_seq_if.master (npc/stall/exc_valid/imem_* in,
//                imem_req/imem_addr/pc/pc_id/ir/ir_valid/fetch_err out)
module pc_fetch_seq
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] EXC_PC   = EXC_PC_DEF,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    pc_fetch_seq_if.master bus
);

    localparam waddr_t RESET_WA = WORD_AW'(RESET_PC >> 2);
    localparam waddr_t EXC_WA   = WORD_AW'(EXC_PC >> 2);

    fetch_state_e r_state;
    fetch_state_e w_state_nxt;
    waddr_t       r_pc;
    waddr_t       w_pc_nxt;
    fetch_pkt_t   r_dec;
    fetch_pkt_t   w_dec_nxt;
    logic         r_ir_valid;
    logic         w_ir_valid_nxt;
    logic         r_exc_pend;
    logic         w_exc_pend_nxt;
    logic         r_fetch_err;
    logic         w_fetch_err_nxt;
    logic         r_imem_req;
    logic         w_tmr_clr;
    logic         w_tmr_en;
    logic         w_tmr_hit;
    logic         w_exc_any;

    fetch_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clr   (w_tmr_clr),
        .i_en    (w_tmr_en),
        .o_hit_c (w_tmr_hit)
    );

    // An exception raised in the same cycle as the ack/timeout is merged with a pending one.
    assign w_exc_any = r_exc_pend | bus.exc_valid;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        w_state_nxt     = r_state;
        w_pc_nxt        = r_pc;
        w_dec_nxt       = r_dec;
        w_exc_pend_nxt  = r_exc_pend;
        w_fetch_err_nxt = 1'b0;
        w_tmr_clr       = 1'b0;
        w_tmr_en        = 1'b0;
        // Decode takes ir whenever it is valid and not stalled.
        w_ir_valid_nxt  = r_ir_valid & bus.stall;

        unique case (r_state)
            ST_IDLE: begin
                w_tmr_clr = 1'b1;
                if (bus.exc_valid) begin
                    w_pc_nxt       = EXC_WA;
                    w_ir_valid_nxt = 1'b0;
                end else begin
                    w_state_nxt = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (bus.exc_valid) begin
                    w_exc_pend_nxt = 1'b1;
                end
                if (bus.imem_ack) begin
                    if (w_exc_any) begin
                        // Instruction belongs to the squashed path: drop it.
                        w_pc_nxt       = EXC_WA;
                        w_ir_valid_nxt = 1'b0;
                        w_exc_pend_nxt = 1'b0;
                        w_state_nxt    = ST_IDLE;
                    end else begin
                        w_dec_nxt.pc   = r_pc;
                        w_dec_nxt.insn = bus.imem_rdata;
                        w_ir_valid_nxt = 1'b1;
                        if (bus.stall) begin
                            w_state_nxt = ST_HOLD;
                        end else begin
                            w_pc_nxt    = bus.npc;
                            w_state_nxt = ST_IDLE;
                        end
                    end
                end else if (w_tmr_hit) begin
                    // Abandon the fetch; a pending exception shares this redirect.
                    w_fetch_err_nxt = 1'b1;
                    w_pc_nxt        = EXC_WA;
                    w_ir_valid_nxt  = 1'b0;
                    w_exc_pend_nxt  = 1'b0;
                    w_state_nxt     = ST_IDLE;
                end else begin
                    w_tmr_en = 1'b1;
                end
            end

            ST_HOLD: begin
                if (bus.exc_valid) begin
                    w_pc_nxt       = EXC_WA;
                    w_ir_valid_nxt = 1'b0;
                    w_state_nxt    = ST_IDLE;
                end else if (!bus.stall) begin
                    // pc_id is frozen in HOLD, so npc is only valid to sample here.
                    w_pc_nxt    = bus.npc;
                    w_state_nxt = ST_IDLE;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // PC, instruction register and handshake outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc        <= RESET_WA;
            r_dec.pc    <= RESET_WA;
            r_dec.insn  <= '0;
            r_ir_valid  <= 1'b0;
            r_exc_pend  <= 1'b0;
            r_fetch_err <= 1'b0;
            r_imem_req  <= 1'b0;
        end else begin
            r_pc        <= w_pc_nxt;
            r_dec       <= w_dec_nxt;
            r_ir_valid  <= w_ir_valid_nxt;
            r_exc_pend  <= w_exc_pend_nxt;
            r_fetch_err <= w_fetch_err_nxt;
            r_imem_req  <= (w_state_nxt == ST_WAIT);
        end
    end

    assign bus.imem_req  = r_imem_req;
    assign bus.imem_addr = r_pc;
    assign bus.pc        = r_pc;
    assign bus.pc_id     = r_dec.pc;
    assign bus.ir        = r_dec.insn;
    assign bus.ir_valid  = r_ir_valid;
    assign bus.fetch_err = r_fetch_err;

endmodule
